// File: rtl/data_mem_responder_if.sv
// Memory-control bus between the datapath (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        LoadSignExt;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Misaligned;

  modport master (
    output MemRead, MemWrite, Size, LoadSignExt, Address, WriteData,
    input  ReadData, Stall, Misaligned
  );

  modport slave (
    input  MemRead, MemWrite, Size, LoadSignExt, Address, WriteData,
    output ReadData, Stall, Misaligned
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM with programmable latency, sub-word RMW stores and extended loads.
// Optional MISALIGN_TRAP_EN: suppress and flag misaligned half/word accesses.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input logic                 Clk,
  input logic                 Rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            sext_q, sext_d;
  logic            store_q, store_d;
  logic            mis_q, mis_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem_q [DEPTH];

  logic            req;
  logic            mis_now;
  logic            stall;
  logic            mem_we;
  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic [31:0]     load_val;
  logic [31:0]     merged;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic            unused_addr_hi;

  assign req            = bus.MemRead | bus.MemWrite;
  assign unused_addr_hi = ^bus.Address[31:AW+2];
  assign idx            = addr_q[AW+1:2];
  assign word           = mem_q[idx];

`ifdef MISALIGN_TRAP_EN
  assign mis_now = ((bus.Size == 2'b01) && bus.Address[0]) ||
                   (bus.Size[1] && (bus.Address[1:0] != 2'b00));
`else
  assign mis_now = 1'b0;
`endif

  // Lane extraction for loads.
  always_comb begin
    sel_byte = word[{addr_q[1:0], 3'b000} +: 8];
    sel_half = word[{addr_q[1], 4'b0000} +: 16];
    load_val = word;
    unique case (size_q)
      2'b00:   load_val = {{24{sext_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_val = {{16{sext_q & sel_half[15]}}, sel_half};
      default: load_val = word;
    endcase
  end

  // Lane merge for stores; untouched bytes keep the current array contents.
  always_comb begin
    merged = word;
    unique case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    store_d = store_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    stall   = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall = req;
        if (req) begin
          addr_d  = bus.Address[AW+1:0];
          wdata_d = bus.WriteData;
          size_d  = bus.Size;
          sext_d  = bus.LoadSignExt;
          store_d = bus.MemWrite;
          mis_d   = mis_now;
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        stall = 1'b1;
        if (!store_q && !mis_q) begin
          rdata_d = load_val;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      store_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      store_q <= store_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_we = (state_q == StAccess) && store_q && !mis_q && !Rst;

  // Array has no reset: contents survive Rst.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[idx] <= merged;
    end
  end

  assign bus.Stall      = stall;
  assign bus.ReadData   = rdata_q;
  assign bus.Misaligned = (state_q == StDone) && mis_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder (DEPTH=1024, LATENCY=2).
module tb_data_mem_responder;

  localparam int unsigned Depth   = 1024;
  localparam int unsigned Latency = 2;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] rd_model;
  exp_t sb[$];

  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH   (Depth),
    .LATENCY (Latency)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drives one request, checks stall length and DONE-cycle outputs.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] load_exp,
                        input logic mis_exp);
    exp_t e;
    exp_t got;
    int   n;
    bit   done;
    e.mis    = mis_exp;
    e.rd     = (wr || mis_exp) ? rd_model : load_exp;
    rd_model = e.rd;
    sb.push_back(e);

    bus.MemRead     = rd;
    bus.MemWrite    = wr;
    bus.Size        = sz;
    bus.LoadSignExt = sx;
    bus.Address     = a;
    bus.WriteData   = wd;

    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.Stall === 1'b1) n++;
      else done = 1'b1;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " stall_len"}, 32'(n), 32'(Latency + 2));
    got = sb.pop_front();
    check({tag, " rdata"}, bus.ReadData, got.rd);
    check({tag, " misaligned"}, 32'(bus.Misaligned), 32'(got.mis));

    @(posedge clk);
    #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.Size        = 2'b10;
    bus.LoadSignExt = 1'b0;
    bus.Address     = '0;
    bus.WriteData   = '0;
    rst             = 1'b1;
    rd_model        = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset stall", 32'(bus.Stall), 32'd0);
    check("reset rdata", bus.ReadData, 32'd0);
    check("reset misaligned", 32'(bus.Misaligned), 32'd0);
    @(posedge clk);
    #1;

    // Seed word 4, then make ReadData non-zero before the reset test.
    access("sw seed", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1111_1111, 32'h0, 1'b0);
    access("lw seed", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1111_1111, 1'b0);

    // Reset held 3 cycles while a SW sits in WAIT.
    bus.MemWrite  = 1'b1;
    bus.Size      = 2'b10;
    bus.Address   = 32'h10;
    bus.WriteData = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.MemWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rd_model = '0;
    @(negedge clk);
    check("midreset stall", 32'(bus.Stall), 32'd0);
    check("midreset rdata", bus.ReadData, 32'd0);
    @(posedge clk);
    #1;
    access("lw after reset", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1111_1111, 1'b0);

    access("sw 0x20", 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 32'h0, 1'b0);
    access("lw 0x20", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0);

    access("sb 0x21", 1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAA, 32'h0, 1'b0);
    access("lw after sb", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1234_AA78, 1'b0);
    access("lb sext", 1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'hFFFF_FFAA, 1'b0);
    access("lb zext", 1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000_00AA, 1'b0);

    access("sh 0x22", 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h7777_8001, 32'h0, 1'b0);
    access("lw after sh", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h8001_AA78, 1'b0);
    access("lh sext", 1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
    access("lh zext", 1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
    access("lb pos sext", 1'b1, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h0000_0078, 1'b0);

`ifdef MISALIGN_TRAP_EN
    access("lw misaligned", 1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1);
`else
    access("lw unaligned", 1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h8001_AA78, 1'b0);
`endif

    // Store wins when both strobes are set; ReadData keeps the previous load.
    access("rw both", 1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_0005, 32'h0, 1'b0);
    access("lw alias", 1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * Depth), 32'h0, 32'h0000_0005, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
